// File: rtl/running_integrator.sv
// running_integrator
//   Discrete-time integrator: result[n] = result[n-1] + slope[n].
//   The first sample after reset/clear is a priming dummy and is discarded.
//   Supports a seed load, signed saturation and a saturating sample counter.
//
// Parameters
//   W       data width of slope/load_value/result (two's complement)
//   CW      width of sample_count
//   STICKY  1: overflow enters FAULT and freezes; 0: clamp and keep integrating
//
// Ports
//   clk           sample clock (posedge)
//   reset         asynchronous active-high reset
//   clear         synchronous clear to IDLE, all values zero
//   load          synchronous seed strobe, loads load_value and enters RUN
//   load_value    seed value (signed)
//   slope         signed difference sample
//   slope_valid   qualifies slope for one cycle
//   result        integrated value (registered)
//   result_valid  one-cycle pulse when result was updated by a sample
//   saturated     sticky overflow flag
//   sample_count  integrated samples since clear/load/reset (saturating)
//   busy          registered (state == RUN)
//   state_dbg     current FSM state, for observation only
//
// Handshake: slope_valid is a single-cycle qualifier with no back-pressure;
// every cycle it is high the sample is consumed, and result_valid pulses
// exactly one cycle later for each sample that was integrated.
module running_integrator #(
  parameter int W      = 64,
  parameter int CW     = 16,
  parameter int STICKY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [W-1:0]  load_value,
  input  logic [W-1:0]  slope,
  input  logic          slope_valid,
  output logic [W-1:0]  result,
  output logic          result_valid,
  output logic          saturated,
  output logic [CW-1:0] sample_count,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          rv_q, rv_d;
  logic          sat_q, sat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  logic [W:0]    sum;
  logic          ovf;
  logic [W-1:0]  clamp_val;
  logic [W-1:0]  next_acc;
  logic [CW-1:0] cnt_inc;

  // One guard bit: the two top bits disagree exactly when the signed add
  // leaves the W-bit range; the guard bit then carries the true sign.
  assign sum       = {acc_q[W-1], acc_q} + {slope[W-1], slope};
  assign ovf       = sum[W] ^ sum[W-1];
  assign clamp_val = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign next_acc  = ovf ? clamp_val : sum[W-1:0];
  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rv_d    = 1'b0;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = '0;
    end else if (load) begin
      // A slope_valid in the same cycle as load is intentionally dropped.
      state_d = S_RUN;
      acc_d   = load_value;
      sat_d   = 1'b0;
      cnt_d   = '0;
    end else if (slope_valid) begin
      case (state_q)
        S_IDLE: state_d = S_RUN;  // priming dummy sample, discarded
        S_RUN: begin
          acc_d = next_acc;
          rv_d  = 1'b1;
          cnt_d = cnt_inc;
          if (ovf) begin
            sat_d = 1'b1;
            if (STICKY != 0) state_d = S_FAULT;
          end
        end
        S_FAULT: state_d = S_FAULT;  // frozen at the clamp value
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rv_q    <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rv_q    <= rv_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_RUN);
    end
  end

  // The accumulator is the result register; in FAULT it holds the clamp value.
  assign result       = acc_q;
  assign result_valid = rv_q;
  assign saturated    = sat_q;
  assign sample_count = cnt_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_running_integrator.sv
// Bench for running_integrator: two W=8, CW=2 instances share the same
// stimulus, one with STICKY=1 (index 0) and one with STICKY=0 (index 1).
module tb_running_integrator;

  localparam int W  = 8;
  localparam int CW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic [W-1:0]  slope = '0;
  logic          slope_valid = 1'b0;

  logic [W-1:0]  res_s, res_n;
  logic          rv_s, rv_n, sat_s, sat_n, busy_s, busy_n;
  logic [CW-1:0] cnt_s, cnt_n;
  logic [1:0]    st_s, st_n;

  running_integrator #(.W(W), .CW(CW), .STICKY(1)) u_sticky (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value(load_value), .slope(slope), .slope_valid(slope_valid),
    .result(res_s), .result_valid(rv_s), .saturated(sat_s),
    .sample_count(cnt_s), .busy(busy_s), .state_dbg(st_s)
  );

  running_integrator #(.W(W), .CW(CW), .STICKY(0)) u_clamp (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value(load_value), .slope(slope), .slope_valid(slope_valid),
    .result(res_n), .result_valid(rv_n), .saturated(sat_n),
    .sample_count(cnt_n), .busy(busy_n), .state_dbg(st_n)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
  endtask

  function automatic logic [31:0] sx(input logic [W-1:0] v);
    return {{(32-W){v[W-1]}}, v};
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for priming sample, 1 = integrating, 2 = frozen
  int m_mode[2];
  int m_acc[2];
  int m_cnt[2];
  bit m_rv[2];
  bit m_sat[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_rv[i] = 0; m_sat[i] = 0;
    end
  endtask

  task automatic model_step(input bit clr, input bit ld, input int lv,
                            input bit sv, input int sl);
    int s;
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = 0;
      if (clr) begin
        m_mode[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
      end else if (ld) begin
        m_mode[i] = 1; m_acc[i] = lv; m_cnt[i] = 0; m_sat[i] = 0;
      end else if (sv) begin
        if (m_mode[i] == 0) begin
          m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
          s = m_acc[i] + sl;
          if (s > 127 || s < -128) begin
            s = (s > 127) ? 127 : -128;
            m_sat[i] = 1;
            if (i == 0) m_mode[i] = 2;
          end
          m_acc[i] = s;
          m_rv[i]  = 1;
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        end
      end
    end
  endtask

  // ---------------- compare process: every cycle ----------------
  always @(negedge clk) begin
    check("s_result", sx(res_s), 32'(m_acc[0]));
    check("s_valid",  {31'b0, rv_s},   {31'b0, m_rv[0]});
    check("s_sat",    {31'b0, sat_s},  {31'b0, m_sat[0]});
    check("s_count",  {30'b0, cnt_s},  32'(m_cnt[0]));
    check("s_busy",   {31'b0, busy_s}, {31'b0, (m_mode[0] == 1)});
    check("n_result", sx(res_n), 32'(m_acc[1]));
    check("n_valid",  {31'b0, rv_n},   {31'b0, m_rv[1]});
    check("n_sat",    {31'b0, sat_n},  {31'b0, m_sat[1]});
    check("n_count",  {30'b0, cnt_n},  32'(m_cnt[1]));
    check("n_busy",   {31'b0, busy_n}, {31'b0, (m_mode[1] == 1)});
  end

  // ---------------- driver ----------------
  // Drives one cycle of inputs from the falling edge, advances the model at
  // the rising edge, returns 1 time unit later with inputs back to idle.
  task automatic drive(input bit clr, input bit ld, input int lv,
                       input bit sv, input int sl);
    @(negedge clk);
    clear       = clr;
    load        = ld;
    load_value  = W'(lv);
    slope_valid = sv;
    slope       = W'(sl);
    @(posedge clk);
    model_step(clr, ld, lv, sv, sl);
    #1;
    clear = 1'b0; load = 1'b0; slope_valid = 1'b0;
  endtask

  task automatic sample(input int sl);
    drive(1'b0, 1'b0, 0, 1'b1, sl);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    check("rst_result", sx(res_s), 0);
    check("rst_busy",   {31'b0, busy_s}, 0);
    check("rst_count",  {30'b0, cnt_s}, 0);

    // Prime + integrate: 0 is discarded, then 5, 10, 7; slope 0 keeps 7.
    sample(0);
    check("t1_prime_valid", {31'b0, rv_s}, 0);
    check("t1_prime_busy",  {31'b0, busy_s}, 1);
    sample(5);
    check("t1_first", sx(res_s), 5);
    sample(5);
    sample(-3);
    check("t1_result", sx(res_s), 7);
    check("t1_count",  {30'b0, cnt_s}, 3);
    sample(0);
    check("t1_zero_result", sx(res_s), 7);
    check("t1_zero_valid",  {31'b0, rv_s}, 1);

    // Seed with coincident sample: the sample is dropped.
    drive(1'b0, 1'b1, 100, 1'b1, 7);
    check("t2_seed",       sx(res_s), 100);
    check("t2_seed_valid", {31'b0, rv_s}, 0);
    check("t2_seed_count", {30'b0, cnt_s}, 0);
    sample(7);
    check("t2_result", sx(res_s), 107);

    // Positive overflow.
    drive(1'b0, 1'b1, 120, 1'b0, 0);
    sample(10);
    check("t3_clamp",  sx(res_s), 127);
    check("t3_sat",    {31'b0, sat_s}, 1);
    check("t3_pulse",  {31'b0, rv_s}, 1);
    check("t3_fault_busy", {31'b0, busy_s}, 0);
    sample(5);
    check("t3_hold",     sx(res_s), 127);
    check("t3_no_pulse", {31'b0, rv_s}, 0);
    check("t3_nonsticky_pulse", {31'b0, rv_n}, 1);
    drive(1'b1, 1'b0, 0, 1'b0, 0);
    check("t3_clear_result", sx(res_s), 0);
    check("t3_clear_sat",    {31'b0, sat_s}, 0);
    check("t3_clear_busy",   {31'b0, busy_s}, 0);

    // Negative overflow; the non-sticky instance keeps integrating.
    drive(1'b0, 1'b1, -120, 1'b0, 0);
    sample(-20);
    check("t4_clamp", sx(res_n), -128);
    sample(30);
    check("t4_result", sx(res_n), -98);
    check("t4_sat",    {31'b0, sat_n}, 1);
    check("t4_count",  {30'b0, cnt_n}, 2);
    check("t4_sticky_frozen", sx(res_s), -128);

    // Asynchronous reset between clock edges while running at 42.
    drive(1'b0, 1'b1, 40, 1'b0, 0);
    sample(2);
    check("t5_before", sx(res_s), 42);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_async_result", sx(res_s), 0);
    check("t5_async_busy",   {31'b0, busy_s}, 0);
    check("t5_async_result_n", sx(res_n), 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    sample(4);
    check("t5_prime_valid", {31'b0, rv_s}, 0);
    sample(4);
    check("t5_result", sx(res_s), 4);

    // Counter saturation at 2^CW-1.
    drive(1'b0, 1'b1, 0, 1'b0, 0);
    for (int k = 0; k < 5; k++) sample(1);
    check("t6_count",  {30'b0, cnt_s}, 3);
    check("t6_result", sx(res_s), 5);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
